// File: rtl/keypad_scanner.sv
//=============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad reader. Strobes one active-low column at a
//               time, samples the active-low row lines through a two-flop
//               synchronizer, builds one scan frame per full column rotation,
//               debounces across frames and hands each accepted key code to
//               the consumer over a valid/ready handshake.
// Ports       : clk_i        - single clock, rising edge
//               reset_ni     - synchronous, active-low reset
//               col_n_o[3:0] - rotating column strobe, exactly one bit low
//               row_n_i[3:0] - row sense lines, active-low, asynchronous
//               key_code_o   - accepted key, row*4 + col
//               key_valid_o  - key_code_o is pending
//               key_ready_i  - consumer takes the code with key_valid_o
//               key_held_o   - a debounced key is down
//               key_lost_o   - one-cycle pulse when an event is dropped
// Options     : define KEYPAD_AUTOREPEAT_EN to emit a repeat event every
//               REPEAT_SCANS frames while a key stays held.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_SCANS = 32
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    output logic [3:0] col_n_o,
    input  logic [3:0] row_n_i,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    input  logic       key_ready_i,
    output logic       key_held_o,
    output logic       key_lost_o
);

    localparam int                 DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]         DEB_TGT  = 4'(DEBOUNCE);

    // Elaboration-time parameter legality
    if (SCAN_DIV < 4) begin : g_bad_scan_div
        $error("keypad_scanner: SCAN_DIV must be at least 4");
    end
    if ((DEBOUNCE < 1) || (DEBOUNCE > 15)) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE must be in 1..15");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_repeat
        $error("keypad_scanner: REPEAT_SCANS must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEB  = 2'd1,
        S_HELD = 2'd2,
        S_REL  = 2'd3
    } state_t;

    //-------------------------------------------------------------------------
    // Row synchronizer
    //-------------------------------------------------------------------------
    logic [3:0] row_s1_q;
    logic [3:0] row_s2_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row_n_i;
            row_s2_q <= row_s1_q;
        end
    end

    //-------------------------------------------------------------------------
    // Column dwell timer and strobe rotation
    //-------------------------------------------------------------------------
    logic [DIV_W-1:0] dwell_q;
    logic [1:0]       col_q;
    logic [3:0]       col_n_q;
    logic             dwell_end;
    logic             frame_end;

    assign dwell_end = (dwell_q == DIV_LAST);
    assign frame_end = dwell_end && (col_q == 2'd3);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            dwell_q <= '0;
            col_q   <= 2'd0;
            col_n_q <= 4'b1110;
        end else if (dwell_end) begin
            dwell_q <= '0;
            col_q   <= col_q + 2'd1;
            col_n_q <= {col_n_q[2:0], col_n_q[3]};
        end else begin
            dwell_q <= dwell_q + DIV_W'(1);
        end
    end

    //-------------------------------------------------------------------------
    // Frame capture: bit {row,col} is set when that key reads as pressed.
    // Each column dwell overwrites only its own four bits, so a frame never
    // needs an explicit clear.
    //-------------------------------------------------------------------------
    logic [15:0] frame_q;
    logic [15:0] frame_d;

    always_comb begin
        frame_d = frame_q;
        for (int r = 0; r < 4; r++) begin
            frame_d[{2'(r), col_q}] = ~row_s2_q[r];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            frame_q <= '0;
        end else if (dwell_end) begin
            frame_q <= frame_d;
        end
    end

    // Frame result: single key vs none; two or more keys count as none
    logic [4:0] n_down;
    logic [3:0] hit_idx;
    logic       single;

    always_comb begin
        n_down  = '0;
        hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_d[i]) begin
                n_down  = n_down + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    assign single = (n_down == 5'd1);

    //-------------------------------------------------------------------------
    // Debounce FSM, evaluated once per frame end
    //-------------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] cand_q,  cand_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] cnt_inc;
    logic       is_cand;
    logic       emit;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int               RPT_W   = $clog2(REPEAT_SCANS + 1);
    localparam logic [RPT_W-1:0] RPT_TGT = RPT_W'(REPEAT_SCANS);
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [RPT_W-1:0] rpt_inc;
    assign rpt_inc = (rpt_q == {RPT_W{1'b1}}) ? rpt_q : rpt_q + RPT_W'(1);
`endif

    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    assign is_cand = single && (hit_idx == cand_q);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_d   = rpt_q;
`endif
        if (frame_end) begin
            case (state_q)
                S_IDLE: begin
                    if (single) begin
                        cand_d = hit_idx;
                        cnt_d  = 4'd1;
                        if (DEB_TGT == 4'd1) begin
                            emit    = 1'b1;
                            state_d = S_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rpt_d   = '0;
`endif
                        end else begin
                            state_d = S_DEB;
                        end
                    end
                end
                S_DEB: begin
                    if (!single) begin
                        state_d = S_IDLE;
                    end else if (is_cand) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB_TGT) begin
                            emit    = 1'b1;
                            state_d = S_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rpt_d   = '0;
`endif
                        end
                    end else begin
                        cand_d = hit_idx;
                        cnt_d  = 4'd1;
                    end
                end
                S_HELD: begin
                    if (!is_cand) begin
                        cnt_d = 4'd1;
                        // A one-frame release window needs no REL stay
                        state_d = (DEB_TGT == 4'd1) ? S_IDLE : S_REL;
                    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rpt_inc == RPT_TGT) begin
                            emit  = 1'b1;
                            rpt_d = '0;
                        end else begin
                            rpt_d = rpt_inc;
                        end
`endif
                    end
                end
                default: begin // S_REL
                    if (is_cand) begin
                        state_d = S_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rpt_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB_TGT) begin
                            state_d = S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // State, event issue and handshake registers
    //-------------------------------------------------------------------------
    logic [3:0] code_q;
    logic       valid_q;
    logic       lost_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            lost_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q   <= rpt_d;
`endif
            if (emit) begin
                // A code still waiting without a same-cycle accept is kept;
                // the new event is dropped and flagged instead.
                if (!valid_q || key_ready_i) begin
                    code_q  <= cand_d;
                    valid_q <= 1'b1;
                end else begin
                    lost_q  <= 1'b1;
                end
            end else if (key_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign col_n_o     = col_n_q;
    assign key_code_o  = code_q;
    assign key_valid_o = valid_q;
    assign key_lost_o  = lost_q;
    assign key_held_o  = (state_q == S_HELD) || (state_q == S_REL);

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
//=============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner. A keypad model turns
//               a 16-bit pressed-key set into row levels for the strobed
//               column; a frame-level reference model predicts events,
//               held state, pending code and dropped events.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE     = 2;
    localparam int REPEAT_SCANS = 3;
    localparam int FRAME        = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_held;
    logic        key_lost;
    logic [15:0] keys;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int ev_seen = 0;
    int lost_seen = 0;

    // Reference model state
    int       m_held, m_cand, m_miss, m_rpt, m_run_key, m_run_len;
    bit       m_pending;
    logic [3:0] m_code;

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is strobed
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_n[c] && keys[r*4 + c]) row_n[r] = 1'b0;
            end
        end
    end

    keypad_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE    (DEBOUNCE),
        .REPEAT_SCANS(REPEAT_SCANS)
    ) u_dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .col_n_o    (col_n),
        .row_n_i    (row_n),
        .key_code_o (key_code),
        .key_valid_o(key_valid),
        .key_ready_i(key_ready),
        .key_held_o (key_held),
        .key_lost_o (key_lost)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_cand = 0; m_miss = 0; m_rpt = 0;
        m_run_key = -1; m_run_len = 0;
        m_pending = 1'b0; m_code = 4'h0;
    endtask

    // One frame of the keypad held at k; returns 1 in lost when an event
    // would be dropped because an unaccepted code is still waiting.
    task automatic model_step(input logic [15:0] k, input logic rdy, output int lost);
        int res;
        bit ev;
        lost = 0;
        ev   = 1'b0;
        res  = -1;
        if ($countones(k) == 1) begin
            for (int i = 0; i < 16; i++) if (k[i]) res = i;
        end
        if (rdy) m_pending = 1'b0;
        if (m_held != 0) begin
            if (res == m_cand) begin
                if (m_miss > 0) begin
                    m_miss = 0;
                    m_rpt  = 0;
                end else begin
                    m_rpt++;
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (m_rpt == REPEAT_SCANS) begin
                        ev    = 1'b1;
                        m_rpt = 0;
                    end
`endif
                end
            end else begin
                m_miss++;
                if (m_miss >= DEBOUNCE) begin
                    m_held = 0; m_run_key = -1; m_run_len = 0;
                end
            end
        end else begin
            if (res >= 0 && res == m_run_key) m_run_len++;
            else begin
                m_run_key = res;
                m_run_len = (res >= 0) ? 1 : 0;
            end
            if (res >= 0 && m_run_len >= DEBOUNCE) begin
                ev = 1'b1; m_held = 1; m_cand = res; m_miss = 0; m_rpt = 0;
                m_run_key = -1; m_run_len = 0;
            end
        end
        if (ev) begin
            if (!m_pending) begin
                m_pending = 1'b1;
                m_code    = 4'(m_cand);
            end else begin
                lost = 1;
            end
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        keys      = '0;
        key_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_col_n", col_n, 4'b1110);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        chk("rst_lost", key_lost, 1'b0);
        reset_n = 1'b1;
        model_reset();
    endtask

    // Runs exactly one aligned frame with a fixed key set and ready level
    task automatic run_frame(input logic [15:0] k, input logic rdy, input string tag,
                             input bit check_cols);
        bit         pend_before;
        int         exp_lost;
        int         lost_frame;
        logic [3:0] exp_col;
        keys        = k;
        key_ready   = rdy;
        pend_before = m_pending;
        model_step(k, rdy, exp_lost);
        lost_frame  = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (key_lost) lost_frame++;
            if (i == 0) chk({tag, "_valid_early"}, key_valid, pend_before && !rdy);
            if (check_cols) begin
                exp_col = ~(4'b0001 << (((i + 1) / SCAN_DIV) % 4));
                chk({tag, "_col_n"}, col_n, exp_col);
                chk({tag, "_idle_valid"}, key_valid, 1'b0);
            end
        end
        lost_seen += lost_frame;
        if (key_valid && rdy) ev_seen++;
        chk({tag, "_valid"}, key_valid, m_pending);
        chk({tag, "_held"}, key_held, m_held != 0);
        chk({tag, "_lost"}, lost_frame, exp_lost);
        if (m_pending) chk({tag, "_code"}, key_code, m_code);
    endtask

    initial begin
        int ev0, lost0, pat, len;
        logic [15:0] kpat;
        logic rdy;

        do_reset();
        run_frame(16'h0000, 1'b1, "idle", 1'b1);

        // Row 1 / column 2 -> code 6, held five frames then released
        ev0 = ev_seen;
        repeat (5) run_frame(16'h0040, 1'b1, "key6", 1'b0);
        repeat (3) run_frame(16'h0000, 1'b1, "key6_rel", 1'b0);
        chk("key6_events", ev_seen - ev0, 1);

        // One-frame bounce on key 5
        ev0 = ev_seen;
        run_frame(16'h0020, 1'b1, "bounce", 1'b0);
        repeat (2) run_frame(16'h0000, 1'b1, "bounce_rel", 1'b0);
        chk("bounce_events", ev_seen - ev0, 0);

        // Two keys on row 0 together
        ev0 = ev_seen;
        repeat (6) run_frame(16'h0003, 1'b1, "multi", 1'b0);
        run_frame(16'h0000, 1'b1, "multi_rel", 1'b0);
        chk("multi_events", ev_seen - ev0, 0);

        // Consumer stalled: second press is dropped, first code stays
        lost0 = lost_seen;
        repeat (2) run_frame(16'h0008, 1'b0, "stall3", 1'b0);
        repeat (2) run_frame(16'h0000, 1'b0, "stall_rel", 1'b0);
        repeat (2) run_frame(16'h0200, 1'b0, "stall9", 1'b0);
        chk("stall_code", key_code, 4'h3);
        chk("stall_lost", lost_seen - lost0, 1);
        run_frame(16'h0000, 1'b1, "stall_drain", 1'b0);
        run_frame(16'h0000, 1'b1, "stall_idle", 1'b0);

        // Key F held ten frames past acceptance
        ev0 = ev_seen;
        repeat (12) run_frame(16'h8000, 1'b1, "keyF", 1'b0);
        repeat (2) run_frame(16'h0000, 1'b1, "keyF_rel", 1'b0);
`ifdef KEYPAD_AUTOREPEAT_EN
        chk("keyF_events", ev_seen - ev0, 4);
`else
        chk("keyF_events", ev_seen - ev0, 1);
`endif

        // Pending code and partial frame discarded by a mid-frame reset
        repeat (2) run_frame(16'h0400, 1'b0, "pre_rst", 1'b0);
        key_ready = 1'b0;
        repeat (7) @(negedge clk);
        do_reset();
        run_frame(16'h0000, 1'b1, "post_rst", 1'b1);

        // Randomized runs of none / single / multi patterns
        for (int n = 0; n < 40; n++) begin
            pat = $urandom_range(0, 5);
            case (pat)
                0:       kpat = 16'h0000;
                1:       kpat = 16'h0001 << $urandom_range(0, 15);
                2:       kpat = 16'h0002;
                3:       kpat = 16'h1000;
                4:       kpat = 16'h0002 | 16'h0800;
                default: kpat = 16'h0001 << $urandom_range(12, 15);
            endcase
            len = $urandom_range(1, 4);
            rdy = ($urandom_range(0, 3) != 0);
            repeat (len) run_frame(kpat, rdy, "rand", 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
